// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter.
// Bytes arrive on a valid/ready stream, are queued in a FIFO and serialised
// onto an idle-high RS-232 line.
//   clk, rst      : system clock, asynchronous active-high reset
//   s_valid/s_data: producer word (LSB transmitted first)
//   s_ready       : FIFO not full (decoded from the registered count)
//   rs232_tx      : serial line, registered
//   tx_busy       : frame on the line or FIFO non-empty
//   fifo_count    : words currently queued
// Frame: start, DATA_BITS data, optional parity, STOP_BITS stop bits. Frames
// are chained with no idle gap while the FIFO holds data.
module uart_tx_fifo #(
    parameter int CLK_PER_BIT = 434,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [DATA_BITS-1:0]          s_data,
    output logic                          rs232_tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;
    localparam int CNT_W = $clog2(CLK_PER_BIT);
    localparam int IW    = $clog2(DATA_BITS);
    localparam logic [CW-1:0]    FULL_CNT  = CW'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [IW-1:0]    DATA_LAST = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0]    STOP_LAST = IW'(STOP_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    // FIFO
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        count;
    logic                 push, pop, empty;

    // Engine
    state_t               state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [IW-1:0]        idx, idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 par, par_n;
    logic                 tx_n;
    logic                 bit_end;

    assign empty      = (count == '0);
    assign s_ready    = (count != FULL_CNT);
    assign push       = s_valid && s_ready;
    assign fifo_count = count;
    assign tx_busy    = (state != S_IDLE) || !empty;
    assign bit_end    = (cnt == CNT_LAST);

    // Storage has no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s_data;
    end

    // Pointers wrap naturally since FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // State register (engine state plus datapath registers).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            idx      <= '0;
            shreg    <= '0;
            par      <= 1'b0;
            rs232_tx <= 1'b1;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            idx      <= idx_n;
            shreg    <= shreg_n;
            par      <= par_n;
            rs232_tx <= tx_n;
        end
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (!empty) state_n = S_START;
            S_START: if (bit_end) state_n = S_DATA;
            S_DATA:  if (bit_end && idx == DATA_LAST)
                         state_n = (PARITY != 0) ? S_PAR : S_STOP;
            S_PAR:   if (bit_end) state_n = S_STOP;
            S_STOP:  if (bit_end && idx == STOP_LAST)
                         state_n = empty ? S_IDLE : S_START;
            default: state_n = S_IDLE;
        endcase
    end

    // Output / datapath logic. The line register is loaded with the value
    // belonging to the next state, so rs232_tx changes on the same edge
    // as the state it represents.
    always_comb begin
        pop     = !empty && ((state == S_IDLE) ||
                  (state == S_STOP && bit_end && idx == STOP_LAST));
        cnt_n   = cnt + 1'b1;
        idx_n   = idx;
        shreg_n = shreg;
        par_n   = par;
        tx_n    = 1'b1;

        // Every state change happens at bit_end or out of IDLE, so this
        // clears the bit counter on each state entry.
        if (state == S_IDLE || bit_end) cnt_n = '0;

        if (state_n != state)
            idx_n = '0;
        else if (bit_end && (state == S_DATA || state == S_STOP))
            idx_n = idx + 1'b1;

        if (pop) begin
            shreg_n = mem[rd_ptr];
            par_n   = (^mem[rd_ptr]) ^ (PARITY == 2);
        end else if (state == S_DATA && bit_end) begin
            shreg_n = shreg >> 1;
        end

        case (state_n)
            S_IDLE:  tx_n = 1'b1;
            S_START: tx_n = 1'b0;
            S_DATA:  tx_n = shreg_n[0];
            S_PAR:   tx_n = par_n;
            S_STOP:  tx_n = 1'b1;
            default: tx_n = 1'b1;
        endcase
    end
endmodule
